uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Next-generation UART transmitter that replaces the fixed serializer/parity/mux/FSM transmit chain.
- Adds a buffered ready/valid input FIFO, frame format selectable at run time (parity off/even/odd, 1 or 2 stop bits), and back-to-back frames with no idle gap.
- Sits between the system-side producer and the TX line.
- CLK is the bit clock: one serial bit per CLK cycle.

Parameters:
- DATAWIDTH, 8, data bits per frame (5..16).
- FIFO_DEPTH, 4, number of words buffered (power of 2, >=2).
- CNT_W, $clog2(FIFO_DEPTH+1), width of FIFO_CNT.

Ports:
- CLK  input  1  bit clock, rising edge.
- RST  input  1  reset, synchronous, active-low.
- P_DATA  input  DATAWIDTH  word to send.
- DATA_VALID  input  1  producer has a word on P_DATA.
- DATA_READY  output  1  FIFO can accept; a word is accepted when DATA_VALID and DATA_READY are both high at a CLK edge.
- PAR_EN  input  1  1 = append parity bit.
- PAR_TYP  input  1  0 = even, 1 = odd.
- STOP2  input  1  1 = two stop bits.
- TX_OUT  output  1  serial line, idle high, registered.
- BUSY  output  1  frame in progress, registered.
- FIFO_CNT  output  CNT_W  words currently buffered.

Behaviour:
- Reset (RST=0 at an edge):
  - TX_OUT=1, BUSY=0, FIFO_CNT=0, FSM=IDLE, read/write pointers=0.
  - DATA_READY=0 while RST=0.
  - A reset mid-frame aborts the frame. TX_OUT is high after that edge. FIFO contents are discarded.
- FIFO:
  - DATA_READY = (FIFO_CNT != FIFO_DEPTH), driven from registered count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop at the same edge leave the count unchanged.
  - When full, a pop at edge E raises DATA_READY after E. There is no same-cycle pass-through when full.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. TX_OUT and BUSY are registered from the next state.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - On an edge with FIFO_CNT!=0: pop the head word, latch word, PAR_EN, PAR_TYP and STOP2, go to START.
- START: TX_OUT=0 for 1 cycle, then DATA.
- DATA:
  - Sends latched bits LSB first, 1 cycle each.
  - A bit index counter runs 0..DATAWIDTH-1.
  - After bit DATAWIDTH-1, go to PARITY if latched PAR_EN, else STOP1.
- PARITY: TX_OUT = ^word when even, ~^word when odd; 1 cycle.
- STOP1:
  - TX_OUT=1 for 1 cycle.
  - Next is STOP2 if latched STOP2.
  - Otherwise, if FIFO_CNT!=0, pop and go to START directly (no idle cycle).
  - Otherwise go to IDLE.
- STOP2: TX_OUT=1 for 1 cycle, then the same exit rule as STOP1.
- Latency: word accepted at edge E0 into an empty FIFO with FSM in IDLE → pop at E1 → start bit on TX_OUT after E1.
- Frame length: 1 + DATAWIDTH + PAR_EN + (STOP2?2:1) cycles.
- BUSY is 1 from the start-bit cycle through the last stop cycle. It stays 1 across back-to-back frames.
- Config inputs changing mid-frame have no effect until the next pop.
- DATA_VALID with DATA_READY=0: no accept. The producer must hold P_DATA.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined, the block adds input SEND_BREAK (1 bit).
  - If SEND_BREAK=1 in IDLE, go to state BREAK with TX_OUT=0 and BUSY=1.
  - BREAK lasts while SEND_BREAK=1, minimum 2*(DATAWIDTH+3) cycles, counted by the bit counter extended as needed.
  - Then one STOP1 cycle and normal exit.
  - SEND_BREAK is sampled only in IDLE, and break takes priority over a non-empty FIFO.
- When undefined: no SEND_BREAK port and no BREAK state. Behaviour is exactly as above.

Test Plan:
- Reset release, idle, then push 0xA5 with PAR_EN=0 and STOP2=0 → TX_OUT after the pop edge is 0,1,0,1,0,0,1,0,1,1, then idle 1. BUSY is high for exactly 10 cycles.
- Push 0xA5 with PAR_EN=1 → parity bit 0 with PAR_TYP=0 and 1 with PAR_TYP=1. 11-cycle frame.
- STOP2=1 with PAR_EN=1 → 12-cycle frame ending in two 1s. Toggling STOP2 and PAR_TYP mid-frame does not change the current frame.
- Push 6 words continuously at FIFO_DEPTH=4 →
  - First word is popped, 4 words are buffered, DATA_READY=0, 6th word is held.
  - 6th word is accepted on the edge after the first frame's stop-bit pop.
  - Frames go out back-to-back, BUSY stays high, with no idle cycle between frames.
- Assert RST=0 during data bit 3 → TX_OUT=1, BUSY=0 and FIFO_CNT=0 after that edge. After release, a new word transmits normally.
- With UART_TX_BREAK_EN: SEND_BREAK=1 for 5 cycles at DATAWIDTH=8 → TX_OUT is low for 22 cycles, then 1 stop cycle, then a queued word is sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a ready/valid input FIFO and a frame format chosen per word.
// Define UART_TX_BREAK_EN to add the SEND_BREAK input and the line-break state.
module uart_tx_fifo #(
    parameter int DATAWIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATAWIDTH-1:0] P_DATA,
    input  logic                 DATA_VALID,
    output logic                 DATA_READY,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic                 STOP2,
`ifdef UART_TX_BREAK_EN
    input  logic                 SEND_BREAK,
`endif
    output logic                 TX_OUT,
    output logic                 BUSY,
    output logic [CNT_W-1:0]     FIFO_CNT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef UART_TX_BREAK_EN
    localparam int BREAK_MIN = 2 * (DATAWIDTH + 3);
    localparam int BIT_W     = $clog2(BREAK_MIN);
`else
    localparam int BIT_W     = $clog2(DATAWIDTH);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] head;
    logic                 push, pop, idle_ready;

    state_t               state_q;
    logic                 tx_q, busy_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATAWIDTH-1:0] shift_q;
    logic                 par_en_q, par_bit_q, stop2_q;

    assign DATA_READY = RST && (cnt_q != CNT_W'(FIFO_DEPTH));
    assign push       = DATA_VALID && DATA_READY;
    assign head       = mem_q[rd_ptr_q];

`ifdef UART_TX_BREAK_EN
    assign idle_ready = (state_q == S_IDLE) && !SEND_BREAK;
`else
    assign idle_ready = (state_q == S_IDLE);
`endif

    // The next word leaves the FIFO either from idle or straight out of the last stop bit.
    assign pop = (cnt_q != '0) &&
                 (idle_ready || (state_q == S_STOP1 && !stop2_q) || state_q == S_STOP2);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage is not reset; a slot is only read after the count says it was written.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= P_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (pop) begin
            state_q   <= S_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            shift_q   <= head;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^head) ^ PAR_TYP;
            stop2_q   <= STOP2;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
                    if (SEND_BREAK) begin
                        state_q <= S_BREAK;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        stop2_q <= 1'b0;
                    end
`endif
                end
                S_START: begin
                    state_q <= S_DATA;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    bit_q   <= '0;
                end
                S_DATA: begin
                    if (bit_q == BIT_W'(DATAWIDTH - 1)) begin
                        state_q <= par_en_q ? S_PARITY : S_STOP1;
                        tx_q    <= par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    state_q <= S_STOP1;
                    tx_q    <= 1'b1;
                end
                S_STOP1: begin
                    tx_q <= 1'b1;
                    if (stop2_q) begin
                        state_q <= S_STOP2;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_STOP2: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    // The bit counter saturates at the minimum length; the break then ends with the request.
                    if (bit_q != BIT_W'(BREAK_MIN - 1)) begin
                        bit_q <= bit_q + 1'b1;
                    end else if (!SEND_BREAK) begin
                        state_q <= S_STOP1;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT   = tx_q;
    assign BUSY     = busy_q;
    assign FIFO_CNT = cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: fixed and random frames, FIFO back-pressure,
// mid-frame reset, a randomized stream decoded by a line receiver model, and break when enabled.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          DATA_READY;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic          TX_OUT;
    logic          BUSY;
    logic [CW-1:0] FIFO_CNT;
`ifdef UART_TX_BREAK_EN
    logic          SEND_BREAK;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    bit exp_q[$];

    uart_tx_fifo #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
`ifdef UART_TX_BREAK_EN
        .SEND_BREAK (SEND_BREAK),
`endif
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .FIFO_CNT   (FIFO_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int frame_len(input bit pe, input bit s2);
        return 1 + DW + (pe ? 1 : 0) + (s2 ? 2 : 1);
    endfunction

    // Expected line bits of one frame: start, data LSB first, optional parity, stop bit(s).
    function automatic void append_frame(input logic [DW-1:0] w, input bit pe, input bit pt, input bit s2);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(w[i]);
        if (pe) exp_q.push_back(pt ? ~(^w) : (^w));
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    task automatic test_reset();
        RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'h3C;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        SEND_BREAK = 1'b0;
`endif
        repeat (3) step();
        tests_run++;
        if (TX_OUT !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", TX_OUT); end
        tests_run++;
        if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tests_run++;
        if (FIFO_CNT !== CW'(0)) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", FIFO_CNT); end
        tests_run++;
        if (DATA_READY !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", DATA_READY); end
        DATA_VALID = 1'b0;
        RST = 1'b1;
        #1;
        tests_run++;
        if (DATA_READY !== 1'b1) begin tests_failed++; $display("FAIL release_ready: got %b expected 1", DATA_READY); end
        repeat (2) step();
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_CNT !== CW'(0)) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got tx=%b busy=%b cnt=%0d expected tx=1 busy=0 cnt=0", TX_OUT, BUSY, FIFO_CNT);
        end
    endtask

    task automatic test_frame(input string name, input logic [DW-1:0] w,
                              input bit pe, input bit pt, input bit s2, input bit toggle);
        int len;
        len = frame_len(pe, s2);
        PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        P_DATA = w; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0; P_DATA = DW'($urandom());
        tests_run++;
        if (FIFO_CNT !== CW'(1) || TX_OUT !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s accept: got cnt=%0d tx=%b expected cnt=1 tx=1", name, FIFO_CNT, TX_OUT);
        end
        step();
        tests_run++;
        if (FIFO_CNT !== CW'(0)) begin tests_failed++; $display("FAIL %s pop: got cnt=%0d expected 0", name, FIFO_CNT); end
        exp_q.delete();
        append_frame(w, pe, pt, s2);
        for (int i = 0; i < len; i++) begin
            tests_run++;
            if (TX_OUT !== exp_q[i] || BUSY !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s bit %0d: got tx=%b busy=%b expected tx=%b busy=1", name, i, TX_OUT, BUSY, exp_q[i]);
            end
            if (toggle && i == 3) begin
                PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2;
            end
            step();
        end
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s end: got tx=%b busy=%b expected tx=1 busy=0", name, TX_OUT, BUSY);
        end
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit            pe, pt, s2;
        int            len, last, idx;
        logic [DW-1:0] words [6];
        int            acc_edge [6];
        bit            tx_log [$];
        bit            busy_log [$];
        pe = 1'($urandom_range(0, 1)); pt = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
        len  = frame_len(pe, s2);
        last = 6 * len + 2;
        idx  = 0;
        foreach (words[i]) begin
            words[i]    = DW'($urandom());
            acc_edge[i] = -1;
        end
        PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        P_DATA = words[0]; DATA_VALID = 1'b1;
        for (int k = 1; k <= last; k++) begin
            bit acc;
            acc = DATA_VALID && DATA_READY;
            step();
            if (acc) begin
                acc_edge[idx] = k;
                idx++;
                if (idx < 6) P_DATA = words[idx];
                else DATA_VALID = 1'b0;
            end
            if (k == 5) begin
                tests_run++;
                if (FIFO_CNT !== CW'(DEPTH) || DATA_READY !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_full: got cnt=%0d ready=%b expected cnt=%0d ready=0", FIFO_CNT, DATA_READY, DEPTH);
                end
            end
            tx_log.push_back(TX_OUT);
            busy_log.push_back(BUSY);
        end
        DATA_VALID = 1'b0;
        tests_run++;
        if (idx != 6) begin tests_failed++; $display("FAIL b2b_accepts: got %0d expected 6", idx); end
        tests_run++;
        if (acc_edge[4] != 5) begin tests_failed++; $display("FAIL b2b_fifth_accept: got edge %0d expected 5", acc_edge[4]); end
        tests_run++;
        if (acc_edge[5] != len + 3) begin
            tests_failed++;
            $display("FAIL b2b_held_accept: got edge %0d expected %0d", acc_edge[5], len + 3);
        end
        exp_q.delete();
        foreach (words[i]) append_frame(words[i], pe, pt, s2);
        for (int i = 0; i < 6 * len; i++) begin
            tests_run++;
            if (tx_log[i + 1] !== exp_q[i] || busy_log[i + 1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_line cycle %0d: got tx=%b busy=%b expected tx=%b busy=1", i, tx_log[i + 1], busy_log[i + 1], exp_q[i]);
            end
        end
        tests_run++;
        if (tx_log[last - 1] !== 1'b1 || busy_log[last - 1] !== 1'b0 || FIFO_CNT !== CW'(0)) begin
            tests_failed++;
            $display("FAIL b2b_idle: got tx=%b busy=%b cnt=%0d expected tx=1 busy=0 cnt=0", tx_log[last - 1], busy_log[last - 1], FIFO_CNT);
        end
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] a, b, c;
        a = DW'($urandom()); b = DW'($urandom()); c = DW'($urandom());
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        P_DATA = a; DATA_VALID = 1'b1;
        step();
        P_DATA = b;
        step();
        DATA_VALID = 1'b0;
        repeat (4) step();
        tests_run++;
        if (TX_OUT !== a[3]) begin tests_failed++; $display("FAIL midreset_bit3: got %b expected %b", TX_OUT, a[3]); end
        RST = 1'b0;
        step();
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_CNT !== CW'(0) || DATA_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_state: got tx=%b busy=%b cnt=%0d ready=%b expected 1 0 0 0", TX_OUT, BUSY, FIFO_CNT, DATA_READY);
        end
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_CNT !== CW'(0)) begin
                tests_failed++;
                $display("FAIL midreset_discard cycle %0d: got tx=%b busy=%b cnt=%0d expected 1 0 0", i, TX_OUT, BUSY, FIFO_CNT);
            end
        end
        P_DATA = c; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        step();
        exp_q.delete();
        append_frame(c, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < frame_len(1'b0, 1'b0); i++) begin
            tests_run++;
            if (TX_OUT !== exp_q[i] || BUSY !== 1'b1) begin
                tests_failed++;
                $display("FAIL midreset_new bit %0d: got tx=%b busy=%b expected tx=%b busy=1", i, TX_OUT, BUSY, exp_q[i]);
            end
            step();
        end
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_end: got tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
        end
    endtask

    task automatic test_random_stream(input int n);
        bit            pe, pt, s2;
        logic [DW-1:0] sent [$];
        pe = 1'($urandom_range(0, 1)); pt = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
        PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [DW-1:0] w;
                    int            tries;
                    bit            acc;
                    repeat ($urandom_range(0, 3)) step();
                    w = DW'($urandom());
                    P_DATA = w; DATA_VALID = 1'b1;
                    tries = 0; acc = 1'b0;
                    while (!acc && tries < 200) begin
                        acc = DATA_READY;
                        step();
                        tries++;
                    end
                    DATA_VALID = 1'b0;
                    tests_run++;
                    if (!acc) begin tests_failed++; $display("FAIL stream_accept word %0d: got no accept expected accept", i); end
                    else sent.push_back(w);
                end
            end
            begin
                int got, budget;
                got = 0; budget = 3000;
                while (got < n && budget > 0) begin
                    if (TX_OUT === 1'b0) begin
                        logic [DW-1:0] w, e;
                        bit            par;
                        par = 1'b0;
                        tests_run++;
                        if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL stream_busy frame %0d: got %b expected 1", got, BUSY); end
                        for (int b = 0; b < DW; b++) begin step(); budget--; w[b] = TX_OUT; end
                        if (pe) begin step(); budget--; par = TX_OUT; end
                        step(); budget--;
                        tests_run++;
                        if (TX_OUT !== 1'b1) begin tests_failed++; $display("FAIL stream_stop1 frame %0d: got %b expected 1", got, TX_OUT); end
                        if (s2) begin
                            step(); budget--;
                            tests_run++;
                            if (TX_OUT !== 1'b1) begin tests_failed++; $display("FAIL stream_stop2 frame %0d: got %b expected 1", got, TX_OUT); end
                        end
                        tests_run++;
                        if (sent.size() == 0) begin
                            tests_failed++;
                            $display("FAIL stream_order frame %0d: got frame %0h expected no frame", got, w);
                        end else begin
                            e = sent.pop_front();
                            if (w !== e) begin tests_failed++; $display("FAIL stream_data frame %0d: got %0h expected %0h", got, w, e); end
                            if (pe) begin
                                tests_run++;
                                if (par !== (pt ? ~(^e) : (^e))) begin
                                    tests_failed++;
                                    $display("FAIL stream_parity frame %0d: got %b expected %b", got, par, pt ? ~(^e) : (^e));
                                end
                            end
                        end
                        got++;
                    end
                    step(); budget--;
                end
                tests_run++;
                if (got != n) begin tests_failed++; $display("FAIL stream_timeout: got %0d frames expected %0d", got, n); end
            end
        join
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_CNT !== CW'(0)) begin
            tests_failed++;
            $display("FAIL stream_idle: got tx=%b busy=%b cnt=%0d expected 1 0 0", TX_OUT, BUSY, FIFO_CNT);
        end
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        logic [DW-1:0] w;
        int            low, k;
        w = DW'($urandom());
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        P_DATA = w; DATA_VALID = 1'b1; SEND_BREAK = 1'b1;
        step();
        DATA_VALID = 1'b0;
        tests_run++;
        if (TX_OUT !== 1'b0 || BUSY !== 1'b1 || FIFO_CNT !== CW'(1)) begin
            tests_failed++;
            $display("FAIL break_entry: got tx=%b busy=%b cnt=%0d expected 0 1 1", TX_OUT, BUSY, FIFO_CNT);
        end
        low = 1; k = 1;
        while (TX_OUT === 1'b0 && k < 200) begin
            if (k == 5) SEND_BREAK = 1'b0;
            step();
            k++;
            if (TX_OUT === 1'b0) low++;
        end
        SEND_BREAK = 1'b0;
        tests_run++;
        if (low != 2 * (DW + 3)) begin tests_failed++; $display("FAIL break_length: got %0d expected %0d", low, 2 * (DW + 3)); end
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL break_stop: got tx=%b busy=%b expected tx=1 busy=1", TX_OUT, BUSY);
        end
        step();
        exp_q.delete();
        append_frame(w, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < frame_len(1'b0, 1'b0); i++) begin
            tests_run++;
            if (TX_OUT !== exp_q[i] || BUSY !== 1'b1) begin
                tests_failed++;
                $display("FAIL break_word bit %0d: got tx=%b busy=%b expected tx=%b busy=1", i, TX_OUT, BUSY, exp_q[i]);
            end
            step();
        end
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_end: got tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
        end
    endtask
`endif

    initial begin
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        test_reset();
        test_frame("a5_plain",        8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        test_frame("a5_even",         8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        test_frame("a5_odd",          8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        test_frame("a5_stop2_toggle", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            test_frame("random", DW'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        test_back_to_back();
        test_back_to_back();
        test_reset_midframe();
        test_random_stream(12);
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
